token_matcher: RTL
==================

TOKEN_MATCHER -- requirements
Module: token_matcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, vocabulary depth 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter WORD_LENGTH, default 3, characters per entry.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per character; entry width EW = WORD_LENGTH*DATA_WIDTH, character 0 in the MSBs.
REQ-004 SHALL have parameter NUM_LANES, default 2, entries compared per cycle; a power of two dividing 2**ADDR_WIDTH.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  vocabulary write strobe; wr_addr  in  ADDR_WIDTH; wr_word  in  EW; wr_valid  in  1  entry valid bit (0 = null entry).
REQ-008 req_valid  in  1; req_ready  out  1; req_word  in  EW; req_start  in  ADDR_WIDTH; req_end  in  ADDR_WIDTH  inclusive search window.
REQ-009 rsp_valid  out  1; rsp_ready  in  1; rsp_found  out  1; rsp_index  out  ADDR_WIDTH; rsp_range_err  out  1.

Function
REQ-010 FSM states IDLE, SCAN, RESP; req_ready SHALL be 1 only in IDLE.
REQ-011 Request accepted on edge E0 with req_valid&&req_ready; req_word/req_start/req_end latched, later input changes ignored.
REQ-012 req_start > req_end: SHALL go to RESP with rsp_found=0, rsp_index=0, rsp_range_err=1, rsp_valid high after E1; no RAM reads.
REQ-013 SCAN: group g = addr/NUM_LANES; one group read per cycle from group(req_start) to group(req_end), synchronous read, 1-cycle latency, compare pipelined behind read.
REQ-014 Lanes outside [req_start, req_end] or with valid bit 0 SHALL never match.
REQ-015 Lowest matching address in a group wins; scan SHALL stop at first matching group.
REQ-016 Response on match at group offset k = group(a)-group(req_start): rsp_valid high after edge E(2+k), rsp_found=1, rsp_index=a.
REQ-017 No match: rsp_valid high after E(2+group(req_end)-group(req_start)), rsp_found=0, rsp_index=0, rsp_range_err=0.
REQ-018 RESP: all rsp_* outputs held stable until rsp_valid&&rsp_ready, then IDLE next cycle.
REQ-019 Writes accepted in any state; a write and a read of the same address in one cycle SHALL return old data (read-first).
REQ-020 Address arithmetic SHALL be unsigned ADDR_WIDTH; scan SHALL never wrap past the top entry.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, req_ready=1 (once released), rsp_valid=0, rsp_found=0, rsp_index=0, rsp_range_err=0.
REQ-022 Reset SHALL clear every entry valid bit; entry data SHALL NOT be reset.
REQ-023 Reset mid-SCAN/RESP SHALL abandon the request with no response.

Configuration
REQ-024 Macro TOKEN_MATCHER_PREFIX_EN defined: port req_len  in  $clog2(WORD_LENGTH+1), latched at accept; only first req_len characters compared; req_len=0 matches any valid entry; req_len>WORD_LENGTH treated as WORD_LENGTH.
REQ-025 Macro undefined: req_len absent, full-word compare.

Structure
REQ-026 Package token_matcher_pkg SHALL hold the FSM state enum and EW/lane-index localparams/functions.
REQ-027 Sub-module match_bank SHALL implement one lane: 2**ADDR_WIDTH/NUM_LANES entries plus valid bits, one write port, one synchronous read port; instantiated NUM_LANES times (lane = addr % NUM_LANES).

Verification (ADDR_WIDTH=4, WORD_LENGTH=3, DATA_WIDTH=8, NUM_LANES=2)
REQ-028 Write "Hel" (48656C) valid at 5 and 9; search "Hel", 0..15 -> rsp after E4, found=1, index=5.
REQ-029 Search "abc" 0..15 -> rsp after E9, found=0, index=0, range_err=0; search "Hel" 6..8 -> found=0 (5 and 9 masked).
REQ-030 req_start=10, req_end=3 -> rsp after E1, range_err=1, found=0.
REQ-031 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0; IDLE one cycle after handshake.
REQ-032 rst_n low at E3 of a scan -> rsp_valid=0, no response; after release search "Hel" 0..15 -> found=0.
REQ-033 With TOKEN_MATCHER_PREFIX_EN, req_word 48xxxx, req_len=1, 0..15 -> found=1, index=5.

Source files
------------

// File: rtl/token_matcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : token_matcher_pkg
// Description : Shared types and sizing helpers for the token matcher.
//               Holds the control FSM state encoding and the functions that
//               derive entry width, lane-index width and per-lane address
//               width from the top-level parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package token_matcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bits per vocabulary entry (character 0 occupies the MSBs).
    function automatic int entry_width(input int word_length, input int data_width);
        return word_length * data_width;
    endfunction

    // Number of low address bits that select the lane.
    function automatic int lane_bits(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 0;
    endfunction

    // Address width inside one lane bank (at least one bit).
    function automatic int bank_addr_bits(input int addr_width, input int num_lanes);
        int gw;
        gw = addr_width - lane_bits(num_lanes);
        return (gw > 0) ? gw : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/token_matcher_match_bank.sv
`default_nettype none
// ============================================================================
// Module      : match_bank
// Description : One lane of the vocabulary store. DEPTH entries of EW bits
//               plus a per-entry valid bit, one write port and one
//               synchronous read port. Read-first: a same-cycle write and
//               read of one address returns the old contents.
//               Valid bits are cleared by reset; entry data is not.
// Ports       : clk, rst_n            - clock, async active-low reset
//               i_wr_en/addr/data/valid - write port
//               i_rd_en/addr          - read request
//               o_rd_data/o_rd_valid  - registered read result
// Revision    : 1.0 - initial release
// ============================================================================
module match_bank #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int EW    = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [EW-1:0] i_wr_data,
    input  logic          i_wr_valid,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [EW-1:0] o_rd_data,
    output logic          o_rd_valid
);

    logic [EW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [EW-1:0]    r_rd_data;
    logic             r_rd_valid;

    // Data array carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_vld[i_wr_addr] <= i_wr_valid;
            end
            if (i_rd_en) begin
                r_rd_valid <= r_vld[i_rd_addr];
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: rtl/token_matcher.sv
`default_nettype none
// ============================================================================
// Module      : token_matcher
// Description : Vocabulary search engine. Searches an inclusive address
//               window for the lowest valid entry equal to the request word,
//               scanning NUM_LANES entries per cycle (one group per cycle).
//               Optional macro TOKEN_MATCHER_PREFIX_EN adds port req_len and
//               compares only the first req_len characters.
// Ports       : clk, rst_n                          - clock, async reset
//               wr_en/wr_addr/wr_word/wr_valid      - vocabulary write
//               req_valid/req_ready/req_word/
//               req_start/req_end[/req_len]         - search request
//               rsp_valid/rsp_ready/rsp_found/
//               rsp_index/rsp_range_err             - search response
// Revision    : 1.0 - initial release
// ============================================================================
module token_matcher
    import token_matcher_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_LANES   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] wr_word,
    input  logic                              wr_valid,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] req_word,
    input  logic [ADDR_WIDTH-1:0]             req_start,
    input  logic [ADDR_WIDTH-1:0]             req_end,
`ifdef TOKEN_MATCHER_PREFIX_EN
    input  logic [$clog2(WORD_LENGTH+1)-1:0]  req_len,
`endif
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_found,
    output logic [ADDR_WIDTH-1:0]             rsp_index,
    output logic                              rsp_range_err
);

    localparam int EW    = entry_width(WORD_LENGTH, DATA_WIDTH);
    localparam int LB    = lane_bits(NUM_LANES);
    localparam int BAW   = bank_addr_bits(ADDR_WIDTH, NUM_LANES);
    localparam int DEPTH = (2 ** ADDR_WIDTH) / NUM_LANES;

    state_t                r_state, w_state_nxt;
    logic [EW-1:0]         r_word;
    logic [ADDR_WIDTH-1:0] r_start, r_end;
    logic                  r_range_err;
    logic [ADDR_WIDTH-1:0] r_issue_grp;     // next group to read
    logic                  r_issue_done;    // last group already read
    logic                  r_cmp_valid;     // bank outputs hold a group to compare
    logic [ADDR_WIDTH-1:0] r_cmp_grp;
    logic                  r_cmp_last;
    logic                  r_rsp_found;
    logic [ADDR_WIDTH-1:0] r_rsp_index;
    logic                  r_rsp_range_err;

    logic [ADDR_WIDTH-1:0] w_end_grp;
    logic                  w_issue_last;
    logic                  w_rd_en;
    logic [BAW-1:0]        w_rd_bank_addr, w_wr_bank_addr;
    logic [EW-1:0]         w_bank_data [NUM_LANES];
    logic [NUM_LANES-1:0]  w_bank_vld;
    logic [EW-1:0]         w_mask;
    logic [ADDR_WIDTH-1:0] w_lane_addr;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_hit_addr;

    assign w_end_grp      = r_end >> LB;
    assign w_issue_last   = (r_issue_grp == w_end_grp);
    assign w_rd_en        = (r_state == ST_SCAN) && !r_range_err && !r_issue_done;
    assign w_rd_bank_addr = BAW'(r_issue_grp);
    assign w_wr_bank_addr = BAW'(wr_addr >> LB);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic w_we;
        assign w_we = wr_en && ((wr_addr & ADDR_WIDTH'(NUM_LANES - 1)) == ADDR_WIDTH'(l));

        match_bank #(
            .DEPTH (DEPTH),
            .AW    (BAW),
            .EW    (EW)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_en    (w_we),
            .i_wr_addr  (w_wr_bank_addr),
            .i_wr_data  (wr_word),
            .i_wr_valid (wr_valid),
            .i_rd_en    (w_rd_en),
            .i_rd_addr  (w_rd_bank_addr),
            .o_rd_data  (w_bank_data[l]),
            .o_rd_valid (w_bank_vld[l])
        );
    end

`ifdef TOKEN_MATCHER_PREFIX_EN
    logic [$clog2(WORD_LENGTH+1)-1:0] r_len;

    // Character i takes part only when i < req_len; a length above
    // WORD_LENGTH therefore enables every character.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (i < int'(r_len)) begin
                w_mask[EW-1-i*DATA_WIDTH -: DATA_WIDTH] = '1;
            end
        end
    end
`else
    assign w_mask = '1;
`endif

    // Descending loop so the lowest in-window matching lane wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_addr  = '0;
        w_lane_addr = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            w_lane_addr = (r_cmp_grp << LB) | ADDR_WIDTH'(l);
            if (w_bank_vld[l] && (w_lane_addr >= r_start) && (w_lane_addr <= r_end) &&
                (((w_bank_data[l] ^ r_word) & w_mask) == '0)) begin
                w_hit      = 1'b1;
                w_hit_addr = w_lane_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (r_range_err) begin
                    w_state_nxt = ST_RESP;
                end else if (r_cmp_valid && (w_hit || r_cmp_last)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word          <= '0;
            r_start         <= '0;
            r_end           <= '0;
            r_range_err     <= 1'b0;
            r_issue_grp     <= '0;
            r_issue_done    <= 1'b0;
            r_cmp_valid     <= 1'b0;
            r_cmp_grp       <= '0;
            r_cmp_last      <= 1'b0;
            r_rsp_found     <= 1'b0;
            r_rsp_index     <= '0;
            r_rsp_range_err <= 1'b0;
`ifdef TOKEN_MATCHER_PREFIX_EN
            r_len           <= '0;
`endif
        end else begin
            // Compare stage tracks the read issued one cycle earlier.
            r_cmp_valid <= w_rd_en;
            r_cmp_grp   <= r_issue_grp;
            r_cmp_last  <= w_issue_last;
            if (w_rd_en) begin
                if (w_issue_last) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_issue_grp <= r_issue_grp + ADDR_WIDTH'(1);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_word          <= req_word;
                        r_start         <= req_start;
                        r_end           <= req_end;
                        r_range_err     <= (req_start > req_end);
                        r_issue_grp     <= req_start >> LB;
                        r_issue_done    <= 1'b0;
                        r_rsp_found     <= 1'b0;
                        r_rsp_index     <= '0;
                        r_rsp_range_err <= 1'b0;
`ifdef TOKEN_MATCHER_PREFIX_EN
                        r_len           <= req_len;
`endif
                    end
                end
                ST_SCAN: begin
                    if (r_range_err) begin
                        r_rsp_range_err <= 1'b1;
                    end else if (r_cmp_valid && w_hit) begin
                        r_rsp_found <= 1'b1;
                        r_rsp_index <= w_hit_addr;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_found     <= 1'b0;
                        r_rsp_index     <= '0;
                        r_rsp_range_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign rsp_valid     = (r_state == ST_RESP);
    assign rsp_found     = r_rsp_found;
    assign rsp_index     = r_rsp_index;
    assign rsp_range_err = r_rsp_range_err;

endmodule
`default_nettype wire
